pim_conv_collector: RTL

- Consumer-side counterpart of the PIM conv top.
- Receives the per-address ADC_P-bit crossbar results as the address counter sweeps 0..DEPTH-1, accumulates them over NUM_PASS input passes (input slices) into a DEPTH-entry buffer, then streams the finished sums downstream with a valid/ready handshake.
- Sits between the PIM conv top and the output feature-map writer.

---
 rtl/pim_pkg.sv | 23 ++
 rtl/pim_conv_collector_if.sv | 26 ++
 rtl/pim_sat_acc.sv | 32 +++
 rtl/pim_conv_collector.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared constants, state encoding and clogb2 for the PIM conv blocks
package pim_pkg;

  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_ADC_P = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } pim_state_t;

  // Never returns less than 1 so a single-entry depth still gets a legal vector.
  function automatic int clogb2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/pim_conv_collector_if.sv
// rtl/pim_conv_collector_if.sv - result input and drained-sum output stream of the collector
interface pim_conv_collector_if #(
  parameter int ADC_P = 8,
  parameter int ACC_W = 16,
  parameter int AW    = 5
);

  logic             in_valid;
  logic [ADC_P-1:0] in_data;
  logic [AW-1:0]    in_addr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [AW-1:0]    out_addr;

  modport master (
    output in_valid, in_data, in_addr, out_ready,
    input  out_valid, out_data, out_addr
  );

  modport slave (
    input  in_valid, in_data, in_addr, out_ready,
    output out_valid, out_data, out_addr
  );

endinterface

// File: rtl/pim_sat_acc.sv
// rtl/pim_sat_acc.sv - saturating accumulate; PIM_SHIFT_ADD_EN weights the addend by 2^shift
module pim_sat_acc #(
  parameter int ACC_W = 16,
  parameter int SH_W  = 2
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  input  logic [SH_W-1:0]  shift,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

`ifdef PIM_SHIFT_ADD_EN
  // Wide enough for the largest shift plus the carry, so saturation is exact.
  localparam int WIDE_W = ACC_W + (1 << SH_W) + 1;
  logic [WIDE_W-1:0] weighted;
  assign weighted = WIDE_W'(addend) << shift;
`else
  localparam int WIDE_W = ACC_W + 1;
  logic [WIDE_W-1:0] weighted;
  logic              shift_unused;
  assign weighted     = WIDE_W'(addend);
  assign shift_unused = ^shift;
`endif

  logic [WIDE_W-1:0] total;

  assign total = WIDE_W'(acc) + weighted;
  assign sat   = |total[WIDE_W-1:ACC_W];
  assign sum   = sat ? {ACC_W{1'b1}} : total[ACC_W-1:0];

endmodule

// File: rtl/pim_conv_collector.sv
// rtl/pim_conv_collector.sv - accumulates NUM_PASS sweeps of PIM results, then drains them; PIM_SHIFT_ADD_EN selects bit-serial weighting
module pim_conv_collector
  import pim_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int ADC_P    = DEFAULT_ADC_P,
  parameter  int ACC_W    = 16,
  parameter  int NUM_PASS = 4,
  localparam int AW       = clogb2(DEPTH),
  localparam int PW       = clogb2(NUM_PASS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  pim_conv_collector_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  addr_err
);

  pim_state_t       state;
  pim_state_t       state_next;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [PW-1:0]    pass_cnt;
  logic [ACC_W-1:0] acc_mem [DEPTH];

  logic             start_ok;
  logic             collect_beat;
  logic             wr_wrap;
  logic             last_beat;
  logic             drain_accept;
  logic             last_accept;
  logic [ACC_W-1:0] acc_prev;
  logic [ACC_W-1:0] acc_sum;
  logic             acc_sat;

  // done is high in the first IDLE cycle; a start then is treated as arriving too early.
  assign start_ok     = start && !done;
  assign collect_beat = (state == COLLECT) && bus.in_valid;
  assign wr_wrap      = (wr_ptr == AW'(DEPTH - 1));
  assign last_beat    = collect_beat && wr_wrap && (pass_cnt == PW'(NUM_PASS - 1));
  assign drain_accept = (state == DRAIN) && bus.out_ready;
  assign last_accept  = drain_accept && (rd_ptr == AW'(DEPTH - 1));

  // Pass 0 overwrites instead of adding, so the buffer never needs clearing.
  assign acc_prev = (pass_cnt == '0) ? '0 : acc_mem[wr_ptr];

  pim_sat_acc #(
    .ACC_W (ACC_W),
    .SH_W  (PW)
  ) u_sat_acc (
    .acc    (acc_prev),
    .addend (ACC_W'(bus.in_data)),
    .shift  (pass_cnt),
    .sum    (acc_sum),
    .sat    (acc_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok)    state_next = COLLECT;
      COLLECT: if (last_beat)   state_next = DRAIN;
      DRAIN:   if (last_accept) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    bus.out_valid = (state == DRAIN);
    bus.out_data  = acc_mem[rd_ptr];
    bus.out_addr  = rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (collect_beat) acc_mem[wr_ptr] <= acc_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pass_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      done <= last_accept;
      case (state)
        IDLE: begin
          if (start_ok) begin
            wr_ptr   <= '0;
            pass_cnt <= '0;
            overflow <= 1'b0;
            addr_err <= 1'b0;
          end
        end
        COLLECT: begin
          if (bus.in_valid) begin
            if (bus.in_addr != wr_ptr) addr_err <= 1'b1;
            if (acc_sat)               overflow <= 1'b1;
            if (wr_wrap) begin
              wr_ptr   <= '0;
              pass_cnt <= pass_cnt + PW'(1);
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
            if (last_beat) rd_ptr <= '0;
          end
        end
        DRAIN: begin
          if (bus.in_valid) addr_err <= 1'b1;
          if (bus.out_ready) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
